// File: rtl/sram_pkg.sv
// Shared constants and types for the SRAM read controller.
//   VDD / VSS / VTH : rail and sense-threshold voltages (volts)
//   LVL_MARGIN      : guard band that defines the illegal mid-rail window
//                     (present only when SRAM_RD_LEVEL_CHECK_EN is defined)
//   rd_state_e      : read FSM states
//   cnt_width()     : width of the shared phase counter
package sram_pkg;

  localparam real VDD = 1.5;
  localparam real VSS = 0.0;
  localparam real VTH = 0.8;
`ifdef SRAM_RD_LEVEL_CHECK_EN
  localparam real LVL_MARGIN = 0.2;
`endif

  typedef enum logic [2:0] {
    S_IDLE,
    S_PRECH,
    S_WLON,
    S_SENSE,
    S_HOLD
  } rd_state_e;

  // The counter holds (phase length - 1), so max(a, b) - 1 must fit.
  function automatic int cnt_width(input int a, input int b);
    int m;
    m = (a > b) ? a : b;
    return (m > 1) ? $clog2(m) : 1;
  endfunction

endpackage

// File: rtl/sram_read_ctrl_if.sv
// Request / response handshake between a read client and sram_read_ctrl.
//   rd_req, rd_addr : request and row address (client -> controller)
//   rd_ready        : controller idle and able to accept a request
//   rd_data         : captured word, valid while rd_valid is high
//   rd_valid        : response valid
//   rd_accept       : client takes rd_data
// master = client side, slave = controller side.
interface sram_read_ctrl_if #(
  parameter int AW   = 4,
  parameter int COLS = 8
);
  logic            rd_req;
  logic [AW-1:0]   rd_addr;
  logic            rd_ready;
  logic [COLS-1:0] rd_data;
  logic            rd_valid;
  logic            rd_accept;

  modport master (
    output rd_req, rd_addr, rd_accept,
    input  rd_ready, rd_data, rd_valid
  );

  modport slave (
    input  rd_req, rd_addr, rd_accept,
    output rd_ready, rd_data, rd_valid
  );
endinterface

// File: rtl/sram_vslice.sv
// One column of the sense stage: converts a sensed bitline voltage into a
// logic bit (level >= VTH). With SRAM_RD_LEVEL_CHECK_EN defined it also
// flags a voltage sitting in the ambiguous window (VSS+margin, VDD-margin).
//   level     : sensed column voltage
//   bit_val   : resolved logic value
//   level_err : mid-rail flag (SRAM_RD_LEVEL_CHECK_EN only)
module sram_vslice
  import sram_pkg::*;
(
  input  real  level,
  output logic bit_val
`ifdef SRAM_RD_LEVEL_CHECK_EN
  ,
  output logic level_err
`endif
);

  assign bit_val = (level >= VTH);

`ifdef SRAM_RD_LEVEL_CHECK_EN
  // Open window: exactly VSS+margin or VDD-margin is still considered clean.
  assign level_err = (level > VSS + LVL_MARGIN) && (level < VDD - LVL_MARGIN);
`endif

endmodule

// File: rtl/sram_read_ctrl.sv
// SRAM read sequencer: precharge -> wordline -> sense -> hold the word until
// the client accepts it. One read in flight; requests are not queued.
//   clk, rst_n : clock, asynchronous active-low reset
//   bus        : request/response handshake (slave side)
//   pre_en     : bitline precharge enable (PRECH only)
//   row_rd     : wordline voltages, VDD on the latched row during WLON/SENSE
//   preout     : sensed column voltages
//   rd_err     : mid-rail level seen at capture (SRAM_RD_LEVEL_CHECK_EN only)
// Out-of-range addresses (>= ROWS) are accepted but raise no wordline and
// return an all-zero word.
module sram_read_ctrl
  import sram_pkg::*;
#(
  parameter int ROWS    = 16,
  parameter int COLS    = 8,
  parameter int PRE_CYC = 2,
  parameter int WL_CYC  = 3
) (
  input  logic            clk,
  input  logic            rst_n,
  sram_read_ctrl_if.slave bus,
  output logic            pre_en,
  output real             row_rd [0:ROWS-1],
  input  real             preout [0:COLS-1]
`ifdef SRAM_RD_LEVEL_CHECK_EN
  ,
  output logic            rd_err
`endif
);

  localparam int AW = (ROWS > 1) ? $clog2(ROWS) : 1;
  localparam int CW = cnt_width(PRE_CYC, WL_CYC);

  rd_state_e       state_q, state_d;
  logic [CW-1:0]   cnt_q, cnt_d;
  logic [AW-1:0]   addr_q;
  logic [COLS-1:0] data_q;
  logic [COLS-1:0] col_bits;
  logic            take, capture, done, wl_on, addr_ok;

  // Column slices
`ifdef SRAM_RD_LEVEL_CHECK_EN
  logic [COLS-1:0] col_err;
`endif

  for (genvar c = 0; c < COLS; c++) begin : g_col
    sram_vslice u_slice (
      .level   (preout[c]),
      .bit_val (col_bits[c])
`ifdef SRAM_RD_LEVEL_CHECK_EN
      ,
      .level_err (col_err[c])
`endif
    );
  end

  // Next-state and outputs
  always_comb begin
    // NOTE: every output of this block gets a default first so no path leaves
    // a signal unassigned, which would infer a latch.
    state_d      = state_q;
    cnt_d        = cnt_q;
    take         = 1'b0;
    capture      = 1'b0;
    done         = 1'b0;
    wl_on        = 1'b0;
    pre_en       = 1'b0;
    bus.rd_ready = 1'b0;
    bus.rd_valid = 1'b0;

    case (state_q)
      S_IDLE: begin
        bus.rd_ready = 1'b1;
        if (bus.rd_req) begin
          take    = 1'b1;
          state_d = S_PRECH;
          cnt_d   = CW'(PRE_CYC - 1);
        end
      end
      S_PRECH: begin
        pre_en = 1'b1;
        if (cnt_q == '0) begin
          state_d = S_WLON;
          cnt_d   = CW'(WL_CYC - 1);
        end else begin
          cnt_d = cnt_q - 1'b1;
        end
      end
      S_WLON: begin
        wl_on = 1'b1;
        if (cnt_q == '0) begin
          state_d = S_SENSE;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q - 1'b1;
        end
      end
      S_SENSE: begin
        // Wordline stays up through the capture edge so the bitlines hold.
        wl_on   = 1'b1;
        capture = 1'b1;
        state_d = S_HOLD;
        cnt_d   = '0;
      end
      S_HOLD: begin
        bus.rd_valid = 1'b1;
        if (bus.rd_accept) begin
          done    = 1'b1;
          state_d = S_IDLE;
          cnt_d   = '0;
        end
      end
      default: begin
        state_d = S_IDLE;
        cnt_d   = '0;
      end
    endcase
  end

  assign addr_ok     = (int'(addr_q) < ROWS);
  assign bus.rd_data = data_q;

  // Decoded from the state register, so an asynchronous reset drops the
  // wordline without waiting for a clock edge.
  for (genvar r = 0; r < ROWS; r++) begin : g_row
    assign row_rd[r] = (wl_on && (addr_q == AW'(r))) ? VDD : VSS;
  end

  // State and datapath registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      // NOTE: datapath registers are reset as well so rd_data reads zero and
      // no stale row is decoded after reset.
      addr_q  <= '0;
      data_q  <= '0;
    end else begin
      // NOTE: non-blocking assignments keep every register sampling the
      // pre-edge values regardless of statement order.
      state_q <= state_d;
      cnt_q   <= cnt_d;
      if (take)    addr_q <= bus.rd_addr;
      if (capture) data_q <= addr_ok ? col_bits : '0;
    end
  end

`ifdef SRAM_RD_LEVEL_CHECK_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)       rd_err <= 1'b0;
    else if (capture) rd_err <= |col_err;
    else if (done)    rd_err <= 1'b0;
  end
`endif

endmodule
